// File: rtl/rr_pop_scheduler.sv
// rr_pop_scheduler
// Round-robin pop scheduler for QUEUE_QUANTITY input FIFOs. Each queue may be
// popped up to BURST_MAX times in a row before the pointer moves on. Downstream
// backpressure (down_full) parks the FSM in STALL with pointer and burst count
// frozen. pop is combinational; out_valid/out_sel are the registered companions
// marking when read data is valid at the data mux (1-cycle read latency).
//
// Build option: define RR_SKIP_EMPTY_EN to make every pointer advance (and the
// IDLE->SERVE entry) jump straight to the next non-empty queue. Without it the
// pointer simply steps by one, and each empty queue costs one SERVE cycle.
module rr_pop_scheduler #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int BURST_MAX      = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enb,
  input  logic [QUEUE_QUANTITY-1:0]         buf_empty,
  input  logic                              down_full,
  output logic [QUEUE_QUANTITY-1:0]         pop,
  output logic [$clog2(QUEUE_QUANTITY)-1:0] selector,
  output logic                              out_valid,
  output logic [$clog2(QUEUE_QUANTITY)-1:0] out_sel,
  output logic [1:0]                        state
);

  localparam int SEL_W = $clog2(QUEUE_QUANTITY);
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [SEL_W-1:0] PTR_LAST   = SEL_W'(QUEUE_QUANTITY - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t           state_reg;
  logic [SEL_W-1:0] ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             out_valid_reg;
  logic [SEL_W-1:0] out_sel_reg;

  logic [SEL_W-1:0] ptr_inc;
  logic [SEL_W-1:0] adv_ptr;    // pointer value loaded on an advance inside SERVE
  logic [SEL_W-1:0] start_ptr;  // pointer value loaded on IDLE->SERVE
  logic             any_ready;
  logic             cur_empty;
  logic             pop_ok;

  assign ptr_inc   = (ptr_reg == PTR_LAST) ? '0 : ptr_reg + 1'b1;
  assign any_ready = ~&buf_empty;
  assign cur_empty = buf_empty[ptr_reg];

  // A pop is only issued from SERVE, enabled, with room downstream and data present.
  assign pop_ok = (state_reg == SERVE) && enb && !down_full && !cur_empty;

  genvar gi;
  generate
    for (gi = 0; gi < QUEUE_QUANTITY; gi++) begin : g_pop
      assign pop[gi] = pop_ok && (ptr_reg == SEL_W'(gi));
    end
  endgenerate

`ifdef RR_SKIP_EMPTY_EN
  // Circular index base+offset, offset in 0..QUEUE_QUANTITY.
  function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= QUEUE_QUANTITY) sum = sum - QUEUE_QUANTITY;
    return SEL_W'(sum);
  endfunction

  // Next non-empty queue: searched from pointer+1 for advances, from the pointer
  // itself for IDLE entry. Scanning from the far end keeps the nearest hit.
  always_comb begin
    adv_ptr   = ptr_inc;
    start_ptr = ptr_reg;
    for (int k = QUEUE_QUANTITY; k >= 1; k--) begin
      if (!buf_empty[wrap_idx(ptr_reg, k)]) adv_ptr = wrap_idx(ptr_reg, k);
    end
    for (int k = QUEUE_QUANTITY - 1; k >= 0; k--) begin
      if (!buf_empty[wrap_idx(ptr_reg, k)]) start_ptr = wrap_idx(ptr_reg, k);
    end
  end
`else
  // Plain round robin: step by one, and enter SERVE at the current pointer.
  always_comb begin
    adv_ptr   = ptr_inc;
    start_ptr = ptr_reg;
  end
`endif

  // FSM, pointer, burst counter and registered read-valid tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_sel_reg   <= '0;
    end else if (enb) begin
      out_valid_reg <= |pop;
      out_sel_reg   <= ptr_reg;
      case (state_reg)
        IDLE: begin
          if (any_ready) begin
            state_reg <= SERVE;
            ptr_reg   <= start_ptr;
          end
        end
        SERVE: begin
          // Backpressure outranks everything, including a burst end.
          if (down_full) begin
            state_reg <= STALL;
          end else if (!any_ready) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (cur_empty) begin
            ptr_reg <= adv_ptr;
            cnt_reg <= '0;
          end else if (cnt_reg == BURST_LAST) begin
            ptr_reg <= adv_ptr;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        STALL: begin
          if (!down_full) state_reg <= SERVE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign selector  = ptr_reg;
  assign out_valid = out_valid_reg;
  assign out_sel   = out_sel_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_rr_pop_scheduler.sv
// tb_rr_pop_scheduler
// Scenario bench for rr_pop_scheduler (QUEUE_QUANTITY=4, BURST_MAX=4). A small
// FIFO-occupancy model drives buf_empty; each scenario carries its own table of
// expected pop/selector/state per cycle and pushes the matching registered
// out_valid/out_sel expectation into a scoreboard queue, popped after the edge.
module tb_rr_pop_scheduler;
  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enb = 1'b0;
  logic [3:0] buf_empty = 4'b1111;
  logic       down_full = 1'b0;
  logic [3:0] pop;
  logic [1:0] selector;
  logic       out_valid;
  logic [1:0] out_sel;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;
  int fifo_cnt[Q];
  logic [2:0] sb[$];

  rr_pop_scheduler #(.QUEUE_QUANTITY(4), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst), .enb(enb), .buf_empty(buf_empty), .down_full(down_full),
    .pop(pop), .selector(selector), .out_valid(out_valid), .out_sel(out_sel), .state(state)
  );

  always #5 clk = ~clk;

  task automatic set_fifos(input int c0, input int c1, input int c2, input int c3);
    fifo_cnt[0] = c0; fifo_cnt[1] = c1; fifo_cnt[2] = c2; fifo_cnt[3] = c3;
    for (int i = 0; i < Q; i++) buf_empty[i] = (fifo_cnt[i] == 0);
  endtask

  // One clock: log the transaction, let the FIFO model consume popped words.
  task automatic tick(input string tag);
    logic [3:0] p;
    p = pop;
    $display("[TB] %s t=%0t pop=%b sel=%0d state=%0d", tag, $time, pop, selector, state);
    @(posedge clk);
    for (int i = 0; i < Q; i++) if (p[i] && fifo_cnt[i] > 0) fifo_cnt[i]--;
    #1;
    for (int i = 0; i < Q; i++) buf_empty[i] = (fifo_cnt[i] == 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    enb = 1'b1;
    down_full = 1'b0;
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    #1;
    enb = 1'b1;
    buf_empty = 4'(($urandom & 32'h7));
    down_full = 1'($urandom & 1);
    rst = 1'b1;
    #2;
    tests++; if (pop !== 4'b0000) begin fails++; $display("FAIL reset_pop: got %b want 0000", pop); end
    tests++; if (selector !== 2'd0) begin fails++; $display("FAIL reset_sel: got %0d want 0", selector); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests++; if (out_sel !== 2'd0) begin fails++; $display("FAIL reset_outsel: got %0d want 0", out_sel); end
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
    @(posedge clk);
    #1;
    tests++;
    if (state !== 2'd0 || pop !== 4'b0000) begin
      fails++; $display("FAIL reset_held: state=%0d pop=%b want state=0 pop=0000", state, pop);
    end
  endtask

  task automatic test_saturation();
    set_fifos(100, 100, 100, 100);
    do_reset();
    for (int k = 0; k < 18; k++) begin
      logic [3:0] ep; int es; int est; logic [2:0] want;
      es  = (k == 0) ? 0 : ((k - 1) / 4) % 4;
      est = (k == 0) ? 0 : 1;
      ep  = (k == 0) ? 4'b0000 : (4'b0001 << es);
      #1;
      tests++;
      if (pop !== ep || selector !== 2'(es) || state !== 2'(est)) begin
        fails++; $display("FAIL saturation c%0d: pop=%b sel=%0d state=%0d want pop=%b sel=%0d state=%0d", k, pop, selector, state, ep, es, est);
      end
      sb.push_back({|ep, 2'(es)});
      tick("saturation");
      want = sb.pop_front();
      tests++;
      if ({out_valid, out_sel} !== want) begin
        fails++; $display("FAIL saturation_out c%0d: valid=%b sel=%0d want valid=%b sel=%0d", k, out_valid, out_sel, want[2], want[1:0]);
      end
    end
  endtask

  task automatic test_drain();
    int qi[5] = '{-1, 0, 0, -1, 1};
    int es[5] = '{0, 0, 0, 0, 1};
    int st[5] = '{0, 1, 1, 1, 1};
    set_fifos(2, 100, 100, 100);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      logic [3:0] ep; logic [2:0] want;
      ep = (qi[k] < 0) ? 4'b0000 : (4'b0001 << qi[k]);
      #1;
      tests++;
      if (pop !== ep || selector !== 2'(es[k]) || state !== 2'(st[k])) begin
        fails++; $display("FAIL drain c%0d: pop=%b sel=%0d state=%0d want pop=%b sel=%0d state=%0d", k, pop, selector, state, ep, es[k], st[k]);
      end
      sb.push_back({|ep, 2'(es[k])});
      tick("drain");
      want = sb.pop_front();
      tests++;
      if ({out_valid, out_sel} !== want) begin
        fails++; $display("FAIL drain_out c%0d: valid=%b sel=%0d want valid=%b sel=%0d", k, out_valid, out_sel, want[2], want[1:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int df[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    int qi[14] = '{-1, 0, 0, 0, 0, 1, 1, -1, -1, -1, -1, 1, 1, 2};
    int es[14] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 2};
    int st[14] = '{0, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 1, 1, 1};
    set_fifos(100, 100, 100, 100);
    do_reset();
    for (int k = 0; k < 14; k++) begin
      logic [3:0] ep; logic [2:0] want;
      down_full = 1'(df[k]);
      ep = (qi[k] < 0) ? 4'b0000 : (4'b0001 << qi[k]);
      #1;
      tests++;
      if (pop !== ep || selector !== 2'(es[k]) || state !== 2'(st[k])) begin
        fails++; $display("FAIL backpressure c%0d: pop=%b sel=%0d state=%0d want pop=%b sel=%0d state=%0d", k, pop, selector, state, ep, es[k], st[k]);
      end
      sb.push_back({|ep, 2'(es[k])});
      tick("backpressure");
      want = sb.pop_front();
      tests++;
      if ({out_valid, out_sel} !== want) begin
        fails++; $display("FAIL backpressure_out c%0d: valid=%b sel=%0d want valid=%b sel=%0d", k, out_valid, out_sel, want[2], want[1:0]);
      end
    end
    down_full = 1'b0;
  endtask

  task automatic test_skip();
`ifdef RR_SKIP_EMPTY_EN
    int qi[5] = '{-1, 2, 2, 2, 2};
    int es[5] = '{0, 2, 2, 2, 2};
`else
    int qi[5] = '{-1, -1, -1, 2, 2};
    int es[5] = '{0, 0, 1, 2, 2};
`endif
    int st[5] = '{0, 1, 1, 1, 1};
    set_fifos(0, 0, 100, 0);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      logic [3:0] ep; logic [2:0] want;
      ep = (qi[k] < 0) ? 4'b0000 : (4'b0001 << qi[k]);
      #1;
      tests++;
      if (pop !== ep || selector !== 2'(es[k]) || state !== 2'(st[k])) begin
        fails++; $display("FAIL skip c%0d: pop=%b sel=%0d state=%0d want pop=%b sel=%0d state=%0d", k, pop, selector, state, ep, es[k], st[k]);
      end
      sb.push_back({|ep, 2'(es[k])});
      tick("skip");
      want = sb.pop_front();
      tests++;
      if ({out_valid, out_sel} !== want) begin
        fails++; $display("FAIL skip_out c%0d: valid=%b sel=%0d want valid=%b sel=%0d", k, out_valid, out_sel, want[2], want[1:0]);
      end
    end
  endtask

  // All queues run dry mid-burst: back to IDLE with a cleared counter, so the
  // next visit to queue 0 gets a full burst of 4.
  task automatic test_idle_return();
    int qi[9] = '{-1, 0, -1, -1, 0, 0, 0, 0, 1};
    int es[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    int st[9] = '{0, 1, 1, 0, 1, 1, 1, 1, 1};
    set_fifos(1, 0, 0, 0);
    do_reset();
    for (int k = 0; k < 9; k++) begin
      logic [3:0] ep; logic [2:0] want;
      ep = (qi[k] < 0) ? 4'b0000 : (4'b0001 << qi[k]);
      #1;
      tests++;
      if (pop !== ep || selector !== 2'(es[k]) || state !== 2'(st[k])) begin
        fails++; $display("FAIL idle_return c%0d: pop=%b sel=%0d state=%0d want pop=%b sel=%0d state=%0d", k, pop, selector, state, ep, es[k], st[k]);
      end
      sb.push_back({|ep, 2'(es[k])});
      tick("idle_return");
      if (k == 2) set_fifos(100, 100, 100, 100);
      want = sb.pop_front();
      tests++;
      if ({out_valid, out_sel} !== want) begin
        fails++; $display("FAIL idle_return_out c%0d: valid=%b sel=%0d want valid=%b sel=%0d", k, out_valid, out_sel, want[2], want[1:0]);
      end
    end
  endtask

  // enb low mid-burst: no pops, counter frozen, out_valid keeps its last value.
  task automatic test_enable();
    int en[8] = '{1, 1, 1, 0, 0, 1, 1, 1};
    int qi[8] = '{-1, 0, 0, -1, -1, 0, 0, 1};
    int es[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    int st[8] = '{0, 1, 1, 1, 1, 1, 1, 1};
    logic [2:0] held;
    set_fifos(100, 100, 100, 100);
    do_reset();
    held = 3'b000;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] ep; logic [2:0] want;
      enb = 1'(en[k]);
      ep = (qi[k] < 0) ? 4'b0000 : (4'b0001 << qi[k]);
      #1;
      tests++;
      if (pop !== ep || selector !== 2'(es[k]) || state !== 2'(st[k])) begin
        fails++; $display("FAIL enable c%0d: pop=%b sel=%0d state=%0d want pop=%b sel=%0d state=%0d", k, pop, selector, state, ep, es[k], st[k]);
      end
      if (en[k] != 0) held = {|ep, 2'(es[k])};
      sb.push_back(held);
      tick("enable");
      want = sb.pop_front();
      tests++;
      if ({out_valid, out_sel} !== want) begin
        fails++; $display("FAIL enable_out c%0d: valid=%b sel=%0d want valid=%b sel=%0d", k, out_valid, out_sel, want[2], want[1:0]);
      end
    end
    enb = 1'b1;
  endtask

  task automatic test_async_reset();
    int qa[6] = '{-1, 0, 0, 0, 0, 1};
    int sa[6] = '{0, 0, 0, 0, 0, 1};
    int ta[6] = '{0, 1, 1, 1, 1, 1};
    set_fifos(100, 100, 100, 100);
    do_reset();
    // Run into the burst on queue 2.
    for (int k = 0; k < 10; k++) begin
      logic [3:0] ep; int es; logic [2:0] want;
      es = (k == 0) ? 0 : ((k - 1) / 4) % 4;
      ep = (k == 0) ? 4'b0000 : (4'b0001 << es);
      #1;
      tests++;
      if (pop !== ep || selector !== 2'(es)) begin
        fails++; $display("FAIL async_pre c%0d: pop=%b sel=%0d want pop=%b sel=%0d", k, pop, selector, ep, es);
      end
      sb.push_back({|ep, 2'(es)});
      tick("async_reset");
      want = sb.pop_front();
      tests++;
      if ({out_valid, out_sel} !== want) begin
        fails++; $display("FAIL async_pre_out c%0d: valid=%b sel=%0d want valid=%b sel=%0d", k, out_valid, out_sel, want[2], want[1:0]);
      end
    end
    #1;
    tests++;
    if (pop !== 4'b0100) begin fails++; $display("FAIL async_midburst: pop=%b want 0100", pop); end
    rst = 1'b1;
    #1;
    tests++;
    if (pop !== 4'b0000 || selector !== 2'd0 || out_valid !== 1'b0 || out_sel !== 2'd0 || state !== 2'd0) begin
      fails++; $display("FAIL async_clear: pop=%b sel=%0d valid=%b out_sel=%0d state=%0d want all zero", pop, selector, out_valid, out_sel, state);
    end
    #1;
    rst = 1'b0;
    sb.delete();
    for (int k = 0; k < 6; k++) begin
      logic [3:0] ep; logic [2:0] want;
      ep = (qa[k] < 0) ? 4'b0000 : (4'b0001 << qa[k]);
      #1;
      tests++;
      if (pop !== ep || selector !== 2'(sa[k]) || state !== 2'(ta[k])) begin
        fails++; $display("FAIL async_post c%0d: pop=%b sel=%0d state=%0d want pop=%b sel=%0d state=%0d", k, pop, selector, state, ep, sa[k], ta[k]);
      end
      sb.push_back({|ep, 2'(sa[k])});
      tick("async_reset");
      want = sb.pop_front();
      tests++;
      if ({out_valid, out_sel} !== want) begin
        fails++; $display("FAIL async_post_out c%0d: valid=%b sel=%0d want valid=%b sel=%0d", k, out_valid, out_sel, want[2], want[1:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_drain();
    test_backpressure();
    test_skip();
    test_idle_return();
    test_enable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_pop_scheduler.md
RR_POP_SCHEDULER -- requirements
Module: rr_pop_scheduler

Interface
REQ-001 The block SHALL have parameter QUEUE_QUANTITY, default 4, giving the number of input FIFOs arbitrated (at least 2).
REQ-002 The block SHALL have parameter BURST_MAX, default 4, giving the maximum consecutive pops from one queue before the pointer advances (at least 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port enb, input, 1 bit: global enable; low freezes all state and forces pop to zero.
REQ-006 The block SHALL have port buf_empty, input, QUEUE_QUANTITY bits: per-FIFO empty flags.
REQ-007 The block SHALL have port down_full, input, 1 bit: downstream backpressure; high forbids pops.
REQ-008 The block SHALL have port pop, output, QUEUE_QUANTITY bits: one-hot or zero FIFO read strobes, combinational.
REQ-009 The block SHALL have port selector, output, $clog2(QUEUE_QUANTITY) bits: current queue pointer, driving the data mux.
REQ-010 The block SHALL have port out_valid, output, 1 bit: registered; high the cycle FIFO read data is valid at the mux.
REQ-011 The block SHALL have port out_sel, output, $clog2(QUEUE_QUANTITY) bits: registered selector value paired with out_valid.
REQ-012 The block SHALL have port state, output, 2 bits: FSM state, encoded IDLE=0, SERVE=1, STALL=2.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, SERVE and STALL, plus a pointer register and a burst counter of width $clog2(BURST_MAX+1).
REQ-014 pop[selector] SHALL be 1 only when state=SERVE, enb=1, down_full=0 and buf_empty[selector]=0; all other pop bits SHALL be 0.
REQ-015 The block SHALL register out_valid <= |pop and out_sel <= selector every enabled edge, giving 1-cycle read latency.
REQ-016 IDLE SHALL go to SERVE when enb=1 and any buf_empty bit is 0; otherwise it holds.
REQ-017 SERVE SHALL go to STALL when down_full=1; STALL SHALL return to SERVE when down_full=0; selector and the burst counter SHALL hold while in STALL.
REQ-018 In SERVE, each pop SHALL increment the burst counter; a pop with counter=BURST_MAX-1 SHALL advance the pointer and clear the counter.
REQ-019 In SERVE with buf_empty[selector]=1 and down_full=0, the block SHALL advance the pointer and clear the counter without popping.
REQ-020 In SERVE with all buf_empty bits 1, the block SHALL go to IDLE, clear the counter and hold the pointer.
REQ-021 Pointer advance SHALL wrap: QUEUE_QUANTITY-1 advances to 0.
REQ-022 When down_full and burst-end occur in the same cycle, down_full SHALL win: no pop, no advance.
REQ-023 When enb=0, no state, pointer, counter or out_valid update SHALL occur; out_valid SHALL hold its value.

Reset
REQ-024 While rst=1, asynchronously: state=IDLE, pointer=0, counter=0, out_valid=0, out_sel=0, and therefore pop=0 and selector=0.
REQ-025 Reset asserted mid-burst SHALL abandon the burst; after release the first grant SHALL start at queue 0 with a fresh burst.

Configuration
REQ-026 The macro RR_SKIP_EMPTY_EN SHALL select the pointer advance mode.
REQ-027 With RR_SKIP_EMPTY_EN defined, every advance (including IDLE->SERVE) SHALL load the first non-empty queue, searched circularly from pointer+1 (from the pointer itself on IDLE->SERVE); if none is non-empty, the pointer SHALL become pointer+1.
REQ-028 With RR_SKIP_EMPTY_EN undefined, every advance SHALL be pointer+1 with wrap, and IDLE->SERVE SHALL keep the pointer, so empty queues each cost one SERVE cycle.

Verification (QUEUE_QUANTITY=4, BURST_MAX=4)
REQ-029 Reset: rst=1 with arbitrary inputs -> pop=0000, selector=0, out_valid=0, state=0, immediately without a clock edge.
REQ-030 Saturation: all queues non-empty, down_full=0, enb=1 -> pop=0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001; out_valid=1 from the second grant cycle onward, with out_sel lagging selector by 1.
REQ-031 Drain: queue 0 holds 2 words, others full -> 2 pops on queue 0, one cycle with pop=0000 and state=SERVE, then pop=0010.
REQ-032 Backpressure: down_full=1 after 2 pops of queue 1 -> state=STALL, pop=0000, selector=1 held; release -> exactly 2 more pops of queue 1, then advance to queue 2.
REQ-033 Skip: only queue 2 non-empty, from IDLE with pointer 0 -> macro defined: selector=2 and pop=0100 on the first SERVE cycle; macro undefined: selector steps 0, 1, 2, and the first pop occurs 2 cycles later.
REQ-034 Async reset mid-burst: rst pulsed between clock edges during pop=0100 -> outputs cleared at once; after release, the next grant is queue 0 with a full burst of 4.
